press_gen: RTL and testbench

Press sequencer driving the two-line count-up/count-down press interface consumed by the press counter: given an 8-bit target, it emits clean, fixed-width `countu`/`countd` press pulses separated by a release gap until its shadow count equals the target. It is used to exercise the counter without physical buttons and to replay stored press counts. It also exposes the shadow count so that it can be compared against the counter's `nr_presses`.

---
 rtl/press_gen_if.sv | 21 ++
 rtl/press_gen.sv | 136 +++++++++++++
 tb/tb_press_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/press_gen_if.sv
// press_gen_if: target/load request side and press-line/status side of the
// press sequencer. master = the agent issuing loads, slave = press_gen.
interface press_gen_if;
  logic [7:0] target;
  logic       load;
  logic       countu;
  logic       countd;
  logic [7:0] nr_presses;
  logic       busy;
  logic       done;

  modport master (
    output target, load,
    input  countu, countd, nr_presses, busy, done
  );

  modport slave (
    input  target, load,
    output countu, countd, nr_presses, busy, done
  );
endinterface

// File: rtl/press_gen.sv
// press_gen: emits fixed-width countu/countd press pulses separated by a
// release gap until the shadow count equals the latched target.
// Optional feature macro: PRESS_GEN_WRAP_EN selects shortest-path modulo-256
// direction; without it the direction is linear and the shadow never wraps.
module press_gen #(
  parameter int PressWidth = 4,
  parameter int GapWidth   = 4
) (
  input  logic     clock0,
  input  logic     reset,
  press_gen_if.slave bus
);

  localparam int MaxW = (PressWidth > GapWidth) ? PressWidth : GapWidth;
  localparam int CW   = (MaxW > 1) ? $clog2(MaxW) : 1;
  localparam logic [CW-1:0] PLast = CW'(PressWidth - 1);
  localparam logic [CW-1:0] GLast = CW'(GapWidth - 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [7:0]    nr_q, nr_d;
  logic          countu_q, countu_d;
  logic          countd_q, countd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // A load in the same cycle as a decision point takes effect for that decision.
  logic [7:0] eff_tgt;
  logic [7:0] diff;
  logic       go_up;

  // Direction for the next press, from the effective target and shadow.
  always_comb begin
    eff_tgt = bus.load ? bus.target : tgt_q;
    diff    = eff_tgt - nr_q;
`ifdef PRESS_GEN_WRAP_EN
    go_up   = (diff != 8'd0) && (diff <= 8'd128);
`else
    go_up   = (eff_tgt > nr_q);
`endif
  end

  // Next-state and next-output logic; outputs are all registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = eff_tgt;
    nr_d     = nr_q;
    countu_d = countu_q;
    countd_d = countd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (diff != 8'd0) begin
            state_d  = PRESS;
            cnt_d    = '0;
            countu_d = go_up;
            countd_d = !go_up;
            busy_d   = 1'b1;
          end else begin
            done_d   = 1'b1;
          end
        end
      end
      PRESS: begin
        if (cnt_q == PLast) begin
          // Press released: shadow follows the line that was held.
          state_d  = GAP;
          cnt_d    = '0;
          countu_d = 1'b0;
          countd_d = 1'b0;
          nr_d     = countu_q ? nr_q + 8'd1 : nr_q - 8'd1;
        end else begin
          cnt_d    = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GLast) begin
          cnt_d = '0;
          if (diff == 8'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = PRESS;
            countu_d = go_up;
            countd_d = !go_up;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        countu_d = 1'b0;
        countd_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= 8'd0;
      nr_q     <= 8'd0;
      countu_q <= 1'b0;
      countd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      nr_q     <= nr_d;
      countu_q <= countu_d;
      countd_q <= countd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.countu     = countu_q;
  assign bus.countd     = countd_q;
  assign bus.nr_presses = nr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_press_gen.sv
// tb_press_gen: scoreboard bench. Stimulus pushes expected press/done events
// into per-instance queues; a negedge monitor detects press releases and done
// pulses and pops/compares. Instance 0 uses P=G=4, instance 1 uses P=G=1.
module tb_press_gen;
  localparam int K_UP = 0, K_DN = 1, K_DONE = 2;

  typedef struct {
    int         kind;
    logic [7:0] nr;
    int         w;    // press width, or done latency; -1 = not checked
    logic       b;    // busy expected at the sample
  } ev_t;

  logic clock0 = 1'b0;
  logic reset  = 1'b0;
  always #5 clock0 = ~clock0;

  logic [7:0] tgt [2];
  logic       ld  [2];

  press_gen_if bus0();
  press_gen_if bus1();
  assign bus0.target = tgt[0];
  assign bus0.load   = ld[0];
  assign bus1.target = tgt[1];
  assign bus1.load   = ld[1];

  press_gen #(.PressWidth(4), .GapWidth(4)) dut0 (
    .clock0(clock0), .reset(reset), .bus(bus0.slave));
  press_gen #(.PressWidth(1), .GapWidth(1)) dut1 (
    .clock0(clock0), .reset(reset), .bus(bus1.slave));

  logic       su [2], sd [2], sb [2], sdn [2];
  logic [7:0] snr [2];
  assign su[0] = bus0.countu;  assign su[1] = bus1.countu;
  assign sd[0] = bus0.countd;  assign sd[1] = bus1.countd;
  assign sb[0] = bus0.busy;    assign sb[1] = bus1.busy;
  assign sdn[0] = bus0.done;   assign sdn[1] = bus1.done;
  assign snr[0] = bus0.nr_presses; assign snr[1] = bus1.nr_presses;

  int  errs = 0, checks = 0;
  int  cyc = 0;
  int  load_cyc [2];
  ev_t exp_q [2][$];
  int  wid [2];
  logic pu [2], pd [2];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_ev(input int i, input int kind, input logic [7:0] nr,
                         input int w, input logic b);
    ev_t e;
    e.kind = kind; e.nr = nr; e.w = w; e.b = b;
    exp_q[i].push_back(e);
  endtask

  // n presses in one direction starting from shadow 'start', then nothing else.
  task automatic push_presses(input int i, input logic [7:0] start, input int n,
                              input bit up, input int w);
    logic [7:0] v;
    v = start;
    for (int k = 0; k < n; k++) begin
      v = up ? v + 8'd1 : v - 8'd1;
      push_ev(i, up ? K_UP : K_DN, v, w, 1'b1);
    end
  endtask

  task automatic compare_ev(input int i, input ev_t g);
    ev_t e;
    checks++;
    if (exp_q[i].size() == 0) begin
      errs++;
      $display("FAIL unexpected_event inst%0d: kind=%0d nr=%0d w=%0d busy=%0b",
               i, g.kind, g.nr, g.w, g.b);
      return;
    end
    e = exp_q[i].pop_front();
    if (e.kind != g.kind || e.nr != g.nr || e.b != g.b || (e.w >= 0 && e.w != g.w)) begin
      errs++;
      $display("FAIL event inst%0d: got kind=%0d nr=%0d w=%0d busy=%0b expected kind=%0d nr=%0d w=%0d busy=%0b",
               i, g.kind, g.nr, g.w, g.b, e.kind, e.nr, e.w, e.b);
    end
  endtask

  // Monitor: reports a press event on each release and a done event on each pulse.
  always @(negedge clock0) begin
    ev_t g;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        wid[i] = 0; pu[i] = 1'b0; pd[i] = 1'b0;
      end else begin
        if (su[i] && sd[i]) begin
          checks++; errs++;
          $display("FAIL overlap inst%0d: countu=1 countd=1 expected never both", i);
        end
        if (su[i] || sd[i]) wid[i]++;
        else if (pu[i] || pd[i]) begin
          g.kind = pu[i] ? K_UP : K_DN; g.nr = snr[i]; g.w = wid[i]; g.b = sb[i];
          compare_ev(i, g);
          wid[i] = 0;
        end
        if (sdn[i]) begin
          g.kind = K_DONE; g.nr = snr[i]; g.w = cyc - load_cyc[i] - 1; g.b = sb[i];
          compare_ev(i, g);
        end
        pu[i] = su[i]; pd[i] = sd[i];
      end
    end
  end

  task automatic do_load(input int i, input logic [7:0] t);
    @(negedge clock0); #1;
    tgt[i] = t; ld[i] = 1'b1; load_cyc[i] = cyc;
    @(negedge clock0); #1;
    ld[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int bound, input string name);
    int c;
    c = 0;
    while (exp_q[i].size() != 0 && c < bound) begin
      @(negedge clock0); #1;
      c++;
    end
    if (exp_q[i].size() != 0) begin
      checks++; errs++;
      $display("FAIL %s timeout: %0d events still pending, expected 0", name, exp_q[i].size());
      exp_q[i].delete();
    end
    repeat (3) @(negedge clock0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock0); #2;
    reset = 1'b0;
    exp_q[0].delete(); exp_q[1].delete();
    @(negedge clock0); #1;
    reset = 1'b1;
  endtask

  initial begin
    int c;
    tgt[0] = 8'd0; tgt[1] = 8'd0; ld[0] = 1'b0; ld[1] = 1'b0;
    load_cyc[0] = 0; load_cyc[1] = 0;
    repeat (2) @(negedge clock0);
    #1;
    chk("rst_countu", bus0.countu, 0);
    chk("rst_countd", bus0.countd, 0);
    chk("rst_busy",   bus0.busy, 0);
    chk("rst_done",   bus0.done, 0);
    chk("rst_nr",     bus0.nr_presses, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock0);

    // Three up presses from 0, done 24 cycles after load.
    push_presses(0, 8'd0, 3, 1'b1, 4);
    push_ev(0, K_DONE, 8'd3, 24, 1'b0);
    do_load(0, 8'd3);
    drain(0, 200, "t_up3");

    // From 3 to 254.
`ifdef PRESS_GEN_WRAP_EN
    push_presses(0, 8'd3, 5, 1'b0, 4);
    push_ev(0, K_DONE, 8'd254, 40, 1'b0);
`else
    push_presses(0, 8'd3, 251, 1'b1, 4);
    push_ev(0, K_DONE, 8'd254, 2008, 1'b0);
`endif
    do_load(0, 8'd254);
    drain(0, 3000, "t_254");
    chk("nr_254", bus0.nr_presses, 254);

    // Shadow 5 then load 5 again: immediate done, no busy, no presses.
    do_reset();
    chk("nr_after_reset", bus0.nr_presses, 0);
    push_presses(0, 8'd0, 5, 1'b1, 4);
    push_ev(0, K_DONE, 8'd5, 40, 1'b0);
    do_load(0, 8'd5);
    drain(0, 200, "t_to5");
    push_ev(0, K_DONE, 8'd5, 0, 1'b0);
    do_load(0, 8'd5);
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock0); #1;
      if (bus0.busy || bus0.countu || bus0.countd) c++;
    end
    chk("same_target_activity", c, 0);
    drain(0, 10, "t_same");

    // Retarget during the second press: 10 -> 1.
    do_reset();
    push_ev(0, K_UP, 8'd1, 4, 1'b1);
    push_ev(0, K_UP, 8'd2, 4, 1'b1);
    push_ev(0, K_DN, 8'd1, 4, 1'b1);
    push_ev(0, K_DONE, 8'd1, -1, 1'b0);
    do_load(0, 8'd10);
    c = 0;
    while (!(bus0.nr_presses == 8'd1 && bus0.countu) && c < 50) begin
      @(negedge clock0); #1;
      c++;
    end
    chk("second_press_seen", (c < 50) ? 1 : 0, 1);
    do_load(0, 8'd1);
    drain(0, 200, "t_retarget");
    chk("nr_retarget", bus0.nr_presses, 1);

    // Reset in the middle of an up press.
    do_reset();
    do_load(0, 8'd3);
    @(negedge clock0); #1;
    chk("midpress_countu", bus0.countu, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_countu", bus0.countu, 0);
    chk("midrst_busy",   bus0.busy, 0);
    chk("midrst_done",   bus0.done, 0);
    chk("midrst_nr",     bus0.nr_presses, 0);
    @(negedge clock0); #1;
    reset = 1'b1;
    c = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock0); #1;
      if (bus0.busy || bus0.countu || bus0.done) c++;
    end
    chk("post_reset_idle", c, 0);

    // P=1, G=1: two single-cycle presses, done 4 cycles after load.
    push_presses(1, 8'd0, 2, 1'b1, 1);
    push_ev(1, K_DONE, 8'd2, 4, 1'b0);
    do_load(1, 8'd2);
    drain(1, 50, "t_p1");
    chk("nr_p1", bus1.nr_presses, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
